clock_alarm_counter: RTL and testbench
======================================

Name: clock_alarm_counter

Overview:
Timekeeping core that sits directly upstream of the 7-segment digit-select mux. It keeps a running BCD time of day (HH:MM:SS) and a user-settable BCD alarm time. It packs both onto a 48-bit bus in the mux's expected order and raises a ring output when the running time reaches the alarm time. Adjustment inputs are single-cycle pulses from the existing debounce stage.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s tick (minimum 2)
RING_SECS, 30, number of seconds alarm_ring stays high unless stopped

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
set_mode  input  1  level; 1 = adjust mode, 0 = run mode
alarm_sel  input  1  level; in adjust mode, 0 = adjust clock time, 1 = adjust alarm time
inc_hour  input  1  pulse; increment selected hour field
inc_min  input  1  pulse; increment selected minute field
clr_sec  input  1  pulse; zero selected seconds field
alarm_en  input  1  level; 1 arms the alarm
alarm_stop  input  1  pulse; silence an active ring
counter  output  48  {al_hour_tens, al_hour_ones, al_min_tens, al_min_ones, al_sec_tens, al_sec_ones, hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones}, 4 bits each, BCD
sec_tick  output  1  one-cycle pulse on each 1 s tick
alarm_ring  output  1  alarm active

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: time = 00:00:00; alarm = 00:00:00; prescaler = 0; sec_tick = 0; alarm_ring = 0; ring counter = 0.
- Prescaler:
  - Counts 0 .. TICK_DIV-1 and wraps.
  - sec_tick is registered and goes high for 1 cycle on the cycle after the prescaler reaches TICK_DIV-1.
  - The time update happens on the same edge that asserts sec_tick.
- Prescaler hold: when set_mode=1 and alarm_sel=0, the prescaler is held at 0, no ticks occur, and the clock time is frozen.
- Time increment on tick (BCD, per digit):
  - sec_ones 9 -> 0 with carry to sec_tens.
  - sec_tens 5 -> 0 with carry to min_ones.
  - Minutes follow the same pattern as seconds.
  - Hour rolls 23 -> 00; hour_ones counts 0-9 when hour_tens < 2 and 0-3 when hour_tens = 2.
  - Consequence: 23:59:59 -> 00:00:00 in one tick.
- Adjustment (accepted only when set_mode=1; ignored in run mode). Target is the clock time if alarm_sel=0, the alarm time if alarm_sel=1.
  - inc_hour: hour +1 modulo 24, no effect on other fields.
  - inc_min: minute +1 modulo 60, no carry into hour.
  - clr_sec: target seconds = 00. When targeting the clock time, it also clears the prescaler.
  - Simultaneous pulses in one cycle are all applied (hour, min and sec fields are independent).
- Alarm adjust while the clock runs (set_mode=1, alarm_sel=1): the clock keeps ticking. Alarm edits do not interact with time carries.
- Alarm match:
  - A match is registered only on a tick edge, when the post-tick time equals the alarm (all 6 digits) and alarm_en=1.
  - On a match, alarm_ring goes to 1 on the edge after the match is detected and the ring counter loads RING_SECS.
  - Manual time edits never trigger the alarm.
- Ring:
  - While ringing, each tick decrements the ring counter. alarm_ring clears on the tick where the counter reaches 0.
  - alarm_stop or alarm_en=0 clears alarm_ring on the next edge. alarm_stop has priority over a match in the same cycle.
  - A new match while ringing reloads RING_SECS.
- counter is driven directly from the registers (no combinational path from inputs). An edit is visible on counter 1 cycle after the pulse.
- Reset asserted mid-ring or mid-adjust: all state returns to reset values on that edge, with no residual ring.
- Out-of-range BCD can never be produced.

Test Plan:
1. TICK_DIV=4, release rst -> sec_tick pulses every 4 cycles; counter[23:0] reads 00:00:01, then 00:00:02, ... ; after 60 ticks it reads 00:01:00.
2. Load 23:59:58 via adjust (set_mode=1, alarm_sel=0: 23 inc_hour, 59 inc_min, then run 58 ticks), run 2 ticks -> 23:59:59, then 00:00:00 with the alarm field unchanged.
3. set_mode=1, alarm_sel=0, pulse inc_min at min 59 -> min 00 and hour unchanged; sec_tick stays 0 for 20 cycles; clr_sec -> seconds 00.
4. Alarm set to 00:00:05 (alarm_sel=1: clr_sec, then 5 ticks impossible, so set alarm 00:01:00 with one inc_min), alarm_en=1, run -> alarm_ring rises the cycle after time hits 00:01:00; with RING_SECS=3 it falls after 3 further ticks.
5. Ring active, pulse alarm_stop -> alarm_ring 0 next cycle; repeat with alarm_en=1 -> no ring until next match.
6. Assert rst while ringing at 12:34:56 -> counter = 0, alarm_ring = 0, sec_tick = 0 on the next edge; the alarm does not fire at 00:00:00 with alarm 00:00:00 until a tick-driven match occurs (24 h later).

Source files
------------

// File: rtl/clock_alarm_counter.sv
// clock_alarm_counter: BCD time-of-day and alarm registers for the 7-segment mux.
// A prescaler turns clk into a 1 s tick. Adjust pulses edit either the clock time
// or the alarm time. A small FSM drives alarm_ring for a limited number of seconds.
//
// Ring FSM states
//   state       | meaning
//   RING_IDLE   | alarm silent, waiting for a tick-driven match
//   RING_ACTIVE | alarm_ring high, ring_cnt counts the remaining seconds
module clock_alarm_counter #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int RING_SECS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_mode,
    input  logic        alarm_sel,
    input  logic        inc_hour,
    input  logic        inc_min,
    input  logic        clr_sec,
    input  logic        alarm_en,
    input  logic        alarm_stop,
    output logic [47:0] counter,
    output logic        sec_tick,
    output logic        alarm_ring
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int RW = (RING_SECS < 1) ? 1 : $clog2(RING_SECS + 1);

    typedef enum logic {RING_IDLE, RING_ACTIVE} ring_state_t;

    logic [PW-1:0] psc;
    logic [3:0]    t_ht, t_ho, t_mt, t_mo, t_st, t_so;
    logic [3:0]    a_ht, a_ho, a_mt, a_mo, a_st, a_so;
    logic [3:0]    n_ht, n_ho, n_mt, n_mo, n_st, n_so;
    logic [3:0]    na_ht, na_ho, na_mt, na_mo, na_st, na_so;
    logic [RW-1:0] ring_cnt, ring_cnt_n;
    ring_state_t   ring_state, ring_state_n;
    logic          hold, edit_alarm, tick_now, match;

    function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd2 && o == 4'd3) return 8'h00;
        else if (o == 4'd9)         return {t + 4'd1, 4'd0};
        else                        return {t, o + 4'd1};
    endfunction

    // Shared by minutes and seconds: 00..59 wrap, no carry out.
    function automatic logic [7:0] sixty_inc(input logic [3:0] t, input logic [3:0] o);
        if (o != 4'd9)      return {t, o + 4'd1};
        else if (t == 4'd5) return 8'h00;
        else                return {t + 4'd1, 4'd0};
    endfunction

    // Clock-time edits freeze the prescaler, so edits and ticks never collide.
    assign hold       = set_mode & ~alarm_sel;
    assign edit_alarm = set_mode & alarm_sel;
    assign tick_now   = ~hold && (psc == PW'(TICK_DIV - 1));

    // sec_tick high means the time registers were just advanced, so this compares the post-tick time.
    assign match = sec_tick && alarm_en &&
                   ({t_ht, t_ho, t_mt, t_mo, t_st, t_so} == {a_ht, a_ho, a_mt, a_mo, a_st, a_so});

    // Next clock time: manual edits while held, BCD carry chain on a tick.
    always_comb begin
        {n_ht, n_ho, n_mt, n_mo, n_st, n_so} = {t_ht, t_ho, t_mt, t_mo, t_st, t_so};
        if (hold) begin
            if (inc_hour) {n_ht, n_ho} = hour_inc(t_ht, t_ho);
            if (inc_min)  {n_mt, n_mo} = sixty_inc(t_mt, t_mo);
            if (clr_sec)  {n_st, n_so} = 8'h00;
        end else if (tick_now) begin
            {n_st, n_so} = sixty_inc(t_st, t_so);
            if (t_st == 4'd5 && t_so == 4'd9) begin
                {n_mt, n_mo} = sixty_inc(t_mt, t_mo);
                if (t_mt == 4'd5 && t_mo == 4'd9) {n_ht, n_ho} = hour_inc(t_ht, t_ho);
            end
        end
    end

    // Next alarm time: edits only, independent of the running clock.
    always_comb begin
        {na_ht, na_ho, na_mt, na_mo, na_st, na_so} = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
        if (edit_alarm) begin
            if (inc_hour) {na_ht, na_ho} = hour_inc(a_ht, a_ho);
            if (inc_min)  {na_mt, na_mo} = sixty_inc(a_mt, a_mo);
            if (clr_sec)  {na_st, na_so} = 8'h00;
        end
    end

    // Prescaler, tick pulse and time/alarm registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc      <= '0;
            sec_tick <= 1'b0;
            {t_ht, t_ho, t_mt, t_mo, t_st, t_so} <= '0;
            {a_ht, a_ho, a_mt, a_mo, a_st, a_so} <= '0;
        end else begin
            // A clock-target clr_sec always happens under hold, which already zeroes the prescaler.
            if (hold || tick_now) psc <= '0;
            else                  psc <= psc + PW'(1);
            sec_tick <= tick_now;
            {t_ht, t_ho, t_mt, t_mo, t_st, t_so} <= {n_ht, n_ho, n_mt, n_mo, n_st, n_so};
            {a_ht, a_ho, a_mt, a_mo, a_st, a_so} <= {na_ht, na_ho, na_mt, na_mo, na_st, na_so};
        end
    end

    // Ring FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_state <= RING_IDLE;
            ring_cnt   <= '0;
        end else begin
            ring_state <= ring_state_n;
            ring_cnt   <= ring_cnt_n;
        end
    end

    // Ring FSM next state: stop/disable beats a match, a match beats the countdown.
    always_comb begin
        ring_state_n = ring_state;
        ring_cnt_n   = ring_cnt;
        case (ring_state)
            RING_IDLE: begin
                if (match && !alarm_stop) begin
                    ring_state_n = RING_ACTIVE;
                    ring_cnt_n   = RW'(RING_SECS);
                end
            end
            RING_ACTIVE: begin
                if (alarm_stop || !alarm_en) begin
                    ring_state_n = RING_IDLE;
                    ring_cnt_n   = '0;
                end else if (match) begin
                    ring_cnt_n = RW'(RING_SECS);
                end else if (tick_now) begin
                    if (ring_cnt <= RW'(1)) begin
                        ring_state_n = RING_IDLE;
                        ring_cnt_n   = '0;
                    end else begin
                        ring_cnt_n = ring_cnt - RW'(1);
                    end
                end
            end
            default: begin
                ring_state_n = RING_IDLE;
                ring_cnt_n   = '0;
            end
        endcase
    end

    assign alarm_ring = (ring_state == RING_ACTIVE);
    assign counter    = {a_ht, a_ho, a_mt, a_mo, a_st, a_so, t_ht, t_ho, t_mt, t_mo, t_st, t_so};

endmodule

// File: tb/tb_clock_alarm_counter.sv
// Bench for clock_alarm_counter: directed scenarios plus a random phase, each cycle
// checked against a seconds-of-day reference model.
module tb_clock_alarm_counter;
    localparam int TD = 4;
    localparam int RS = 3;

    logic        clk = 1'b0;
    logic        rst, set_mode, alarm_sel, inc_hour, inc_min, clr_sec, alarm_en, alarm_stop;
    logic [47:0] counter;
    logic        sec_tick, alarm_ring;

    int total = 0;
    int bad   = 0;

    // Reference model state: times as seconds since midnight.
    int m_psc, m_t, m_al, m_rcnt;
    bit m_tick, m_ring;

    clock_alarm_counter #(.TICK_DIV(TD), .RING_SECS(RS)) dut (
        .clk(clk), .rst(rst), .set_mode(set_mode), .alarm_sel(alarm_sel),
        .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec),
        .alarm_en(alarm_en), .alarm_stop(alarm_stop),
        .counter(counter), .sec_tick(sec_tick), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int edit(input int t, input bit ih, input bit im, input bit cs);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (ih) h = (h + 1) % 24;
        if (im) m = (m + 1) % 60;
        if (cs) s = 0;
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from the current inputs, then compare after the edge.
    task automatic step();
        bit hold, tick, match;
        int psc_n, t_n, al_n, rcnt_n;
        bit ring_n;
        hold  = set_mode && !alarm_sel;
        tick  = !hold && (m_psc == TD - 1);
        match = m_tick && alarm_en && (m_t == m_al);
        psc_n = (hold || tick) ? 0 : m_psc + 1;
        t_n   = hold ? edit(m_t, inc_hour, inc_min, clr_sec) : (tick ? (m_t + 1) % 86400 : m_t);
        al_n  = (set_mode && alarm_sel) ? edit(m_al, inc_hour, inc_min, clr_sec) : m_al;
        ring_n = m_ring;
        rcnt_n = m_rcnt;
        if (!m_ring) begin
            if (match && !alarm_stop) begin ring_n = 1; rcnt_n = RS; end
        end else if (alarm_stop || !alarm_en) begin
            ring_n = 0; rcnt_n = 0;
        end else if (match) begin
            rcnt_n = RS;
        end else if (tick) begin
            rcnt_n = m_rcnt - 1;
            if (rcnt_n <= 0) begin ring_n = 0; rcnt_n = 0; end
        end
        if (rst) begin
            psc_n = 0; t_n = 0; al_n = 0; ring_n = 0; rcnt_n = 0; tick = 0;
        end
        m_psc = psc_n; m_t = t_n; m_al = al_n; m_ring = ring_n; m_rcnt = rcnt_n; m_tick = tick;
        @(posedge clk);
        #1;
        check("counter", counter, {bcd(m_al), bcd(m_t)});
        check("sec_tick", 48'(sec_tick), 48'(m_tick));
        check("alarm_ring", 48'(alarm_ring), 48'(m_ring));
    endtask

    task automatic idle_inputs();
        set_mode = 0; alarm_sel = 0; inc_hour = 0; inc_min = 0; clr_sec = 0; alarm_stop = 0; rst = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_edit(input bit sel, input bit ih, input bit im, input bit cs);
        set_mode = 1; alarm_sel = sel; inc_hour = ih; inc_min = im; clr_sec = cs;
        step();
        inc_hour = 0; inc_min = 0; clr_sec = 0;
    endtask

    // Runs in run mode until the DUT rings, within a fixed cycle budget.
    task automatic wait_ring(input string tag);
        bit seen;
        seen = 0;
        set_mode = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (alarm_ring) seen = 1;
        end
        check(tag, 48'(seen), 48'(1));
    endtask

    initial begin
        int ticks, ring_cycles;
        m_psc = 0; m_t = 0; m_al = 0; m_rcnt = 0; m_tick = 0; m_ring = 0;
        idle_inputs();
        alarm_en = 0;
        rst = 1;
        step();
        step();
        check("reset_counter", counter, 48'h0);
        rst = 0;

        // Free run: one tick every TD cycles, 60 ticks reach 00:01:00.
        ticks = 0;
        for (int i = 0; i < 60 * TD; i++) begin
            step();
            if (sec_tick) ticks++;
        end
        check("tick_count_60", 48'(ticks), 48'(60));
        check("time_00_01_00", 48'(counter[23:0]), 48'h000100);

        // Load 23:59:00 (hour 0 +23, minute 1 +58), then run to midnight.
        for (int i = 0; i < 23; i++) pulse_edit(0, 1, 0, 0);
        for (int i = 0; i < 58; i++) pulse_edit(0, 0, 1, 0);
        pulse_edit(0, 0, 0, 1);
        check("time_loaded", 48'(counter[23:0]), 48'h235900);
        idle_inputs();
        run(59 * TD);
        check("time_23_59_59", 48'(counter[23:0]), 48'h235959);
        run(TD);
        check("time_wrap", counter, 48'h0);

        // Held clock: minute wraps without carry, no ticks.
        set_mode = 1; alarm_sel = 0;
        for (int i = 0; i < 59; i++) pulse_edit(0, 0, 1, 0);
        check("min_59", 48'(counter[23:0]), 48'h005900);
        pulse_edit(0, 0, 1, 0);
        check("min_wrap_no_carry", 48'(counter[23:0]), 48'h000000);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sec_tick) ticks++;
        end
        check("hold_no_tick", 48'(ticks), 48'(0));

        // Alarm at 00:01:00 rings for RS ticks.
        pulse_edit(1, 0, 1, 0);
        check("alarm_set", 48'(counter[47:24]), 48'h000100);
        idle_inputs();
        alarm_en = 1;
        ring_cycles = 0;
        for (int i = 0; i < 75 * TD; i++) begin
            step();
            if (alarm_ring) ring_cycles++;
        end
        check("ring_length", 48'(ring_cycles), 48'(RS * TD - 1));

        // alarm_stop silences on the next edge.
        pulse_edit(1, 0, 1, 0);
        wait_ring("ring_at_00_02");
        alarm_stop = 1;
        step();
        alarm_stop = 0;
        check("stop_clears", 48'(alarm_ring), 48'(0));
        run(50);

        // Dropping alarm_en silences too.
        pulse_edit(1, 0, 1, 0);
        wait_ring("ring_at_00_03");
        alarm_en = 0;
        step();
        alarm_en = 1;
        check("en_low_clears", 48'(alarm_ring), 48'(0));

        // Reset mid-ring, then no ring at a zero alarm without a full day.
        pulse_edit(1, 0, 1, 0);
        wait_ring("ring_at_00_04");
        rst = 1;
        step();
        rst = 0;
        check("rst_counter", counter, 48'h0);
        check("rst_ring", 48'(alarm_ring), 48'(0));
        ring_cycles = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (alarm_ring) ring_cycles++;
        end
        check("no_ring_after_rst", 48'(ring_cycles), 48'(0));

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            set_mode   = ($urandom_range(0, 7) == 0);
            alarm_sel  = $urandom_range(0, 1);
            inc_hour   = ($urandom_range(0, 5) == 0);
            inc_min    = ($urandom_range(0, 5) == 0);
            clr_sec    = ($urandom_range(0, 9) == 0);
            alarm_en   = ($urandom_range(0, 15) != 0);
            alarm_stop = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
